// File: rtl/fast_copy_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : fast_copy_encoder_if
//  Description : Message-in / byte-out bundle for fast_copy_encoder.
//                master : message source and byte sink (drives in_valid,
//                         in_msg, dict_clr, out_ready)
//                slave  : the encoder (drives in_ready, out_valid,
//                         out_data, out_last)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fast_copy_encoder_if #(
    parameter int MSG_BITS = 280
) ();
    logic                in_valid;
    logic                in_ready;
    logic [MSG_BITS-1:0] in_msg;
    logic                dict_clr;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_data;
    logic                out_last;

    modport master (
        output in_valid, in_msg, dict_clr, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_msg, dict_clr, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/fast_copy_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : fast_copy_encoder
//  Description : FAST copy-operator encoder. Accepts one decoded message per
//                handshake, applies the copy operator to PID/MC/MT against a
//                one-entry dictionary, and streams pmap, present header
//                bytes, 5 time bytes and 25 body bytes out MSB first.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                bus    - fast_copy_encoder_if.slave (message in, bytes out,
//                         dict_clr)
//  Config      : FAST_ENC_COPY_EN - when defined, builds the dictionary and
//                copy comparators; otherwise pmap is fixed at 16'h8000, all
//                header bytes are sent and dict_clr is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module fast_copy_encoder #(
    parameter int MSG_BITS = 280
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    fast_copy_encoder_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [5:0] c_FULL_LEN = 6'd35;

    state_t         r_state;
    logic [5:0]     r_idx;
    logic [5:0]     r_len;
    logic [271:0]   r_buf;
    logic           r_out_valid;
    logic [7:0]     r_out_data;
    logic           r_out_last;

    logic [7:0]     w_pid;
    logic [7:0]     w_mc;
    logic [7:0]     w_mt;
    logic [239:0]   w_tail;
    logic           w_accept;
    logic           w_copy_pid;
    logic           w_copy_mc;
    logic           w_copy_mt;
    logic [1:0]     w_ncopy;
    logic [15:0]    w_pmap;
    logic [23:0]    w_hdr;
    logic [263:0]   w_stream;
    logic           w_unused_rsvd;

    assign w_pid    = bus.in_msg[279:272];
    assign w_mc     = bus.in_msg[271:264];
    assign w_mt     = bus.in_msg[263:256];
    assign w_tail   = {bus.in_msg[247:208], bus.in_msg[199:0]};
    assign w_unused_rsvd = ^{bus.in_msg[255:248], bus.in_msg[207:200]};

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);

`ifdef FAST_ENC_COPY_EN
    logic [7:0] r_dict_pid;
    logic [7:0] r_dict_mc;
    logic [7:0] r_dict_mt;
    logic       r_dict_vld;

    // A clear arriving with the accepted message wins over the stored entry,
    // so that message is encoded as if the dictionary were empty.
    assign w_copy_pid = r_dict_vld && !bus.dict_clr && (w_pid == r_dict_pid);
    assign w_copy_mc  = r_dict_vld && !bus.dict_clr && (w_mc  == r_dict_mc);
    assign w_copy_mt  = r_dict_vld && !bus.dict_clr && (w_mt  == r_dict_mt);

    // Loading on acceptance takes priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dict_pid <= 8'h00;
            r_dict_mc  <= 8'h00;
            r_dict_mt  <= 8'h00;
            r_dict_vld <= 1'b0;
        end else if (w_accept) begin
            r_dict_pid <= w_pid;
            r_dict_mc  <= w_mc;
            r_dict_mt  <= w_mt;
            r_dict_vld <= 1'b1;
        end else if (bus.dict_clr) begin
            r_dict_vld <= 1'b0;
        end
    end
`else
    logic w_unused_dict_clr;

    assign w_copy_pid        = 1'b0;
    assign w_copy_mc         = 1'b0;
    assign w_copy_mt         = 1'b0;
    assign w_unused_dict_clr = bus.dict_clr;
`endif

    assign w_ncopy = {1'b0, w_copy_pid} + {1'b0, w_copy_mc} + {1'b0, w_copy_mt};
    assign w_pmap  = {1'b1, w_copy_pid, w_copy_mc, w_copy_mt, 12'h000};

    // Present header bytes are packed right-aligned in transmit order; the
    // stream is then shifted up by one byte per copied field so the first
    // present byte lands at the top and the time/body follow without gaps.
    always_comb begin
        w_hdr = 24'h000000;
        if (!w_copy_pid) w_hdr = {w_hdr[15:0], w_pid};
        if (!w_copy_mc)  w_hdr = {w_hdr[15:0], w_mc};
        if (!w_copy_mt)  w_hdr = {w_hdr[15:0], w_mt};
    end

    assign w_stream = {w_hdr, w_tail} << {w_ncopy, 3'b000};

    // The message is held in a byte shift register: out_data always carries
    // the current byte and r_buf[271:264] the next one, so each handshake
    // simply shifts by one byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 6'd0;
            r_len       <= 6'd0;
            r_buf       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_SEND;
                        r_idx       <= 6'd0;
                        r_len       <= c_FULL_LEN - {4'b0000, w_ncopy};
                        r_buf       <= {w_pmap[7:0], w_stream};
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_pmap[15:8];
                        r_out_last  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (bus.out_ready) begin
                        if (r_out_last) begin
                            r_state     <= ST_IDLE;
                            r_idx       <= 6'd0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_idx      <= r_idx + 6'd1;
                            r_out_data <= r_buf[271:264];
                            r_buf      <= {r_buf[263:0], 8'h00};
                            r_out_last <= ((r_idx + 6'd1) == (r_len - 6'd1));
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_fast_copy_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fast_copy_encoder
//  Description : Directed self-checking bench for fast_copy_encoder. Inputs
//                change and outputs are observed on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fast_copy_encoder;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [7:0] exp_q[$];

    fast_copy_encoder_if #(.MSG_BITS(280)) bus ();

    fast_copy_encoder #(.MSG_BITS(280)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Copy hits only exist when the copy operator is built in.
    function automatic logic eff(input logic b);
`ifdef FAST_ENC_COPY_EN
        return b;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [199:0] inc_body();
        logic [199:0] b;
        for (int k = 0; k < 25; k++) b[199-8*k -: 8] = k[7:0];
        return b;
    endfunction

    task automatic build_exp(input logic [7:0] pid, input logic [7:0] mc, input logic [7:0] mt,
                             input logic [39:0] tim, input logic cp, input logic cm, input logic ct);
        logic ep, em, et;
        ep = eff(cp); em = eff(cm); et = eff(ct);
        exp_q.delete();
        exp_q.push_back({1'b1, ep, em, et, 4'b0000});
        exp_q.push_back(8'h00);
        if (!ep) exp_q.push_back(pid);
        if (!em) exp_q.push_back(mc);
        if (!et) exp_q.push_back(mt);
        for (int k = 0; k < 5; k++) exp_q.push_back(tim[39-8*k -: 8]);
        for (int k = 0; k < 25; k++) exp_q.push_back(k[7:0]);
    endtask

    // Called on a falling edge with the block idle; returns on the falling
    // edge right after the acceptance edge.
    task automatic send(input logic [7:0] pid, input logic [7:0] mc, input logic [7:0] mt,
                        input logic [39:0] tim, input logic clr);
        bus.in_msg   = {pid, mc, mt, 8'hA5, tim, 8'h5A, inc_body()};
        bus.in_valid = 1'b1;
        bus.dict_clr = clr;
        chk("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dict_clr = 1'b0;
        bus.in_msg   = ~bus.in_msg;
    endtask

    // Receives exp_q strictly one byte per cycle except on the two stall
    // indices; stops without checking at abort_at.
    task automatic recv(input string tag, input int stall_a, input int stall_b, input int abort_at);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) return;
            if (i == stall_a || i == stall_b) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    chk({tag, "_stall_valid"}, {63'd0, bus.out_valid}, 64'd1);
                    chk({tag, "_stall_data"}, {56'd0, bus.out_data}, {56'd0, exp_q[i]});
                    chk({tag, "_stall_last"}, {63'd0, bus.out_last}, {63'd0, (i == n-1)});
                    chk({tag, "_stall_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
                    @(negedge clk);
                end
            end
            bus.out_ready = 1'b1;
            chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
            chk({tag, "_data"}, {56'd0, bus.out_data}, {56'd0, exp_q[i]});
            chk({tag, "_last"}, {63'd0, bus.out_last}, {63'd0, (i == n-1)});
            @(negedge clk);
        end
        chk({tag, "_done_valid"}, {63'd0, bus.out_valid}, 64'd0);
        chk({tag, "_done_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_msg    = '0;
        bus.dict_clr  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_data",  {56'd0, bus.out_data},  64'd0);
        chk("rst_out_last",  {63'd0, bus.out_last},  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First message: empty dictionary, 35 bytes.
        send(8'h11, 8'h22, 8'h33, 40'h0102030405, 1'b0);
        build_exp(8'h11, 8'h22, 8'h33, 40'h0102030405, 1'b0, 1'b0, 1'b0);
        recv("first", -1, -1, -1);

        // Identical header: all three copied, 32 bytes.
        send(8'h11, 8'h22, 8'h33, 40'h0102030405, 1'b0);
        build_exp(8'h11, 8'h22, 8'h33, 40'h0102030405, 1'b1, 1'b1, 1'b1);
        recv("repeat", -1, -1, -1);

        // Only MC differs: pmap D0, 33 bytes.
        send(8'h11, 8'h99, 8'h33, 40'h0102030405, 1'b0);
        build_exp(8'h11, 8'h99, 8'h33, 40'h0102030405, 1'b1, 1'b0, 1'b1);
        recv("partial", -1, -1, -1);

        // Backpressure on index 2 and on the last byte.
        send(8'h11, 8'h99, 8'h33, 40'hA1B2C3D4E5, 1'b0);
        build_exp(8'h11, 8'h99, 8'h33, 40'hA1B2C3D4E5, 1'b1, 1'b1, 1'b1);
        recv("bp", 2, exp_q.size() - 1, -1);

        // dict_clr coincident with acceptance of a stored header.
        send(8'h11, 8'h99, 8'h33, 40'h0102030405, 1'b1);
        build_exp(8'h11, 8'h99, 8'h33, 40'h0102030405, 1'b0, 1'b0, 1'b0);
        recv("clr_collide", -1, -1, -1);

        send(8'h11, 8'h99, 8'h33, 40'h0102030405, 1'b0);
        build_exp(8'h11, 8'h99, 8'h33, 40'h0102030405, 1'b1, 1'b1, 1'b1);
        recv("after_clr", -1, -1, -1);

        // Reset after ten bytes of a message.
        send(8'h11, 8'h99, 8'h33, 40'h0102030405, 1'b0);
        build_exp(8'h11, 8'h99, 8'h33, 40'h0102030405, 1'b1, 1'b1, 1'b1);
        recv("pre_reset", -1, -1, 10);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("midrst_out_last",  {63'd0, bus.out_last},  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(8'h11, 8'h99, 8'h33, 40'h0102030405, 1'b0);
        build_exp(8'h11, 8'h99, 8'h33, 40'h0102030405, 1'b0, 1'b0, 1'b0);
        recv("post_reset", -1, -1, -1);

        // Standalone dict_clr while idle empties the dictionary.
        bus.dict_clr = 1'b1;
        @(negedge clk);
        bus.dict_clr = 1'b0;
        send(8'h11, 8'h99, 8'h33, 40'h0102030405, 1'b0);
        build_exp(8'h11, 8'h99, 8'h33, 40'h0102030405, 1'b0, 1'b0, 1'b0);
        recv("idle_clr", -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fast_copy_encoder.md
# fast_copy_encoder

Encode-side counterpart of the stage-4 FAST copy-operator decoder. Accepts one decoded market-data message per handshake and applies the FAST copy operator to the three header fields (PID, MC, MT) against a per-block dictionary. Builds the 16-bit presence map and streams the encoded message out as bytes with valid/ready flow control. Sits at the egress of the message-build pipeline, feeding the line-side framer.

## Interface
- `MSG_BITS`, default 280: width of the decoded message word. Fixed layout; no other value is supported.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_msg` holds a message.
- `in_ready` out 1: block can accept a message.
- `in_msg` in `MSG_BITS`: decoded message word.
  - [279:272] PID
  - [271:264] MC
  - [263:256] MT
  - [255:248] reserved
  - [247:208] time (40 b)
  - [207:200] reserved
  - [199:0] body (25 bytes)
- `dict_clr` in 1: invalidates the dictionary.
- `out_valid` out 1: `out_data` holds an encoded byte.
- `out_ready` in 1: downstream accepts the byte.
- `out_data` out 8: encoded byte.
- `out_last` out 1: marks the final byte of a message.

## Operation
- **States:** IDLE, SEND.
  - `in_ready` = 1 only in IDLE.
  - Acceptance occurs when `in_valid & in_ready`. IDLE goes to SEND.
- **At acceptance**, for each field F in {PID, MC, MT}: `copy_F = dict_vld & (in_msg.F == dict_F)`.
- **Presence map:** pmap = {1'b1, copy_PID, copy_MC, copy_MT, 12'b0}. A copy bit of 1 means the field is absent from the stream.
- **Dictionary update at acceptance:** `dict_PID/MC/MT` ← the accepted values; `dict_vld` ← 1.
- **Byte sequence**, every multi-byte field sent MSB first:
  1. pmap[15:8], pmap[7:0]
  2. PID if not copied, then MC if not copied, then MT if not copied
  3. time: 5 bytes
  4. body: 25 bytes
- **Message length:** 32 + (number of fields present) bytes, so 32..35. Reserved bytes are never transmitted.
- **Byte handling in SEND:**
  - Byte index counter: 6 bits, starts at 0, increments on each `out_valid & out_ready`.
  - `out_last` = 1 exactly when index = length−1.
  - A handshake on the last byte returns the block to IDLE.
- **Output stability:** while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_last` hold constant.
- **`dict_clr` behaviour:** sampled every cycle; sets `dict_vld` ← 0.
  - If asserted in the same cycle as acceptance, the accepted message is encoded with all copy bits 0.
  - In that case the dictionary is still loaded with the message's values, leaving `dict_vld` = 1 afterwards.
- **Reset** (including mid-message):
  - Next state IDLE, byte index 0, `dict_vld` = 0, dictionary = 0.
  - Any partially sent message is abandoned without a final `out_last`.

## Timing
- **Reset values:** `in_ready` = 1, `out_valid` = 0, `out_data` = 8'h00, `out_last` = 0.
- **Latency:** acceptance at edge t puts the first byte (pmap[15:8]) on `out_valid` in the cycle following t.
- **Throughput:** one byte per cycle while `out_ready` = 1.
- **Inter-message gap:** `in_ready` rises the cycle after the last-byte handshake. A message therefore costs length + 1 cycles at best.
- **Input side:** `in_msg` is sampled only at the acceptance edge and is registered internally; the source may change it afterwards.
- **`out_ready` timing:** the encoder may assert `out_valid` without waiting for `out_ready`. `out_ready` may toggle at any time.

## Configuration
- **`FAST_ENC_COPY_EN` defined:** copy-operator behaviour exactly as above.
- **`FAST_ENC_COPY_EN` undefined:**
  - Dictionary registers and comparators are not built.
  - pmap is always 16'h8000.
  - All three header bytes are always sent; length is always 35.
  - `dict_clr` is ignored.

## Test plan
- **First message after reset:** PID=8'h11, MC=8'h22, MT=8'h33, time=40'h0102030405, body=incrementing bytes 8'h00..8'h18 → bytes:
  - 80 00 11 22 33
  - 01 02 03 04 05
  - 00..18
  - 35 bytes total, `out_last` on byte 35 only.
- **Same header repeated:** send the first message again → pmap F0 00, no header bytes, 32 bytes, time and body unchanged.
- **Partial match:** PID=8'h11, MC=8'h99, MT=8'h33 after the previous message → pmap D0 00, then 99, then time and body; 33 bytes.
- **Backpressure:** hold `out_ready` = 0 for 4 cycles on byte index 2 and on the last byte → `out_data`/`out_last` stable throughout, no byte lost or duplicated; `in_ready` stays 0 until the final handshake.
- **`dict_clr` collision:** `dict_clr` in the same cycle as accepting a repeat of the stored header → pmap 80 00, 35 bytes; an immediate repeat afterwards → pmap F0 00.
- **Reset mid-message:** assert `rst_n` = 0 after byte 10 → `out_valid` = 0 and `in_ready` = 1 immediately; the next identical message encodes with pmap 80 00.
